// File: rtl/g_nlogic_pipe_pkg.sv
// Shared op codes, skid-buffer state encoding and the reserved-op check
// for the registered N-input logic pipe.
package g_nlogic_pipe_pkg;

   localparam logic [2:0] G_OP_AND  = 3'd0;
   localparam logic [2:0] G_OP_NAND = 3'd1;
   localparam logic [2:0] G_OP_OR   = 3'd2;
   localparam logic [2:0] G_OP_NOR  = 3'd3;
   localparam logic [2:0] G_OP_XOR  = 3'd4;
   localparam logic [2:0] G_OP_XNOR = 3'd5;

   typedef enum logic [1:0] {
      SK_EMPTY = 2'd0,
      SK_ONE   = 2'd1,
      SK_FULL  = 2'd2
   } skid_state_e;

   function automatic logic is_reserved_op(input logic [2:0] op);
      return (op > G_OP_XNOR);
   endfunction

endpackage

// File: rtl/g_nlogic_pipe_if.sv
// Operand/result handshake bundle. Valid/ready: a word moves on a rising
// clock edge exactly when valid and ready are both 1; an offered word is held stable until then.
interface g_nlogic_pipe_if #(
   parameter int NIN = 4,
   parameter int NCH = 1
) ();
   logic [NCH*NIN-1:0] D;
   logic [2:0]         OP;
   logic               VI;
   logic               RDYI;
   logic [NCH-1:0]     Y;
   logic               VO;
   logic               RDYO;

   modport master (output D, output OP, output VI, output RDYO,
                   input RDYI, input Y, input VO);
   modport slave  (input D, input OP, input VI, input RDYO,
                   output RDYI, output Y, output VO);
endinterface

// File: rtl/g_nlogic_pipe_skid.sv
// g_skid2: generic 2-entry valid/ready skid buffer. The main entry drives the
// output; the skid entry absorbs one word while the consumer stalls.
import g_nlogic_pipe_pkg::*;

module g_skid2 #(
   parameter int W = 1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic [W-1:0] in_data_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [W-1:0] out_data_o,
   output skid_state_e state_o
);

   skid_state_e  state_q, state_d;
   logic [W-1:0] main_q, main_d;
   logic [W-1:0] skid_q, skid_d;
   logic         rdy_q, rdy_d;
   logic         accept, deliver;

   assign accept  = in_valid_i & rdy_q;
   assign deliver = (state_q != SK_EMPTY) & out_ready_i;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= SK_EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
         rdy_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         rdy_q   <= rdy_d;
      end
   end

   // rdy_q is 0 only in SK_FULL, so no accept can arrive while the skid entry is occupied.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         SK_EMPTY: begin
            if (accept) begin
               main_d  = in_data_i;
               state_d = SK_ONE;
            end
         end
         SK_ONE: begin
            if (accept && deliver) begin
               main_d = in_data_i;
            end else if (accept) begin
               skid_d  = in_data_i;
               state_d = SK_FULL;
            end else if (deliver) begin
               state_d = SK_EMPTY;
            end
         end
         SK_FULL: begin
            if (deliver) begin
               main_d  = skid_q;
               state_d = SK_ONE;
            end
         end
         default: state_d = SK_EMPTY;
      endcase
      rdy_d = (state_d != SK_FULL);
   end

   assign in_ready_o  = rdy_q;
   assign out_valid_o = (state_q != SK_EMPTY);
   assign out_data_o  = main_q;
   assign state_o     = state_q;

endmodule

// File: rtl/g_nlogic_pipe.sv
// NCH parallel NIN-input reductions with a per-transaction op code, delivered
// through a 2-entry skid buffer; tracks a sticky reserved-op flag and a saturating delivery count.
import g_nlogic_pipe_pkg::*;

module g_nlogic_pipe #(
   parameter int NIN  = 4,
   parameter int NCH  = 1,
   parameter int CNTW = 8
) (
   input  logic              CK,
   input  logic              RN,
   g_nlogic_pipe_if.slave    bus,
   output logic              ERR,
   output logic [CNTW-1:0]   CNT,
   output skid_state_e       dbg_state_o
);

   function automatic logic reduce_ch(input logic [2:0] op, input logic [NIN-1:0] v);
      logic r;
      case (op)
         G_OP_AND:  r = &v;
         G_OP_NAND: r = ~&v;
         G_OP_OR:   r = |v;
         G_OP_NOR:  r = ~|v;
         G_OP_XOR:  r = ^v;
         G_OP_XNOR: r = ~^v;
         default:   r = 1'b0;
      endcase
      return r;
   endfunction

   logic [NCH-1:0]  red;
   logic            accept, deliver;
   logic            err_q, err_d;
   logic [CNTW-1:0] cnt_q, cnt_d;

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      assign red[c] = reduce_ch(bus.OP, bus.D[c*NIN +: NIN]);
   end

   g_skid2 #(.W(NCH + 0)) u_skid (
      .clk_i       (CK),
      .rst_ni      (RN),
      .in_valid_i  (bus.VI),
      .in_ready_o  (bus.RDYI),
      .in_data_i   (red),
      .out_valid_o (bus.VO),
      .out_ready_i (bus.RDYO),
      .out_data_o  (bus.Y),
      .state_o     (dbg_state_o)
   );

   assign accept  = bus.VI & bus.RDYI;
   assign deliver = bus.VO & bus.RDYO;

   always_comb begin
      err_d = err_q | (accept & is_reserved_op(bus.OP));
      cnt_d = cnt_q;
      if (deliver && (cnt_q != {CNTW{1'b1}})) begin
         cnt_d = cnt_q + CNTW'(1);
      end
   end

   always_ff @(posedge CK) begin
      if (!RN) begin
         err_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         err_q <= err_d;
         cnt_q <= cnt_d;
      end
   end

   assign ERR = err_q;
   assign CNT = cnt_q;

endmodule

// File: tb/tb_g_nlogic_pipe.sv
// Directed bench for g_nlogic_pipe: two instances (8-bit and 2-bit counters),
// each step compares outputs against hand-computed values.
import g_nlogic_pipe_pkg::*;

module tb_g_nlogic_pipe;

   logic        CK = 1'b0;
   logic        RN = 1'b0;
   logic        err0, err1;
   logic [7:0]  cnt0;
   logic [1:0]  cnt1;
   skid_state_e st0, st1;
   int          n_assert = 0;
   int          n_fail   = 0;
   logic [1:0]  exp_ops [6] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b00, 2'b11};

   always #5 CK = ~CK;

   g_nlogic_pipe_if #(.NIN(4), .NCH(2)) bus0 ();
   g_nlogic_pipe_if #(.NIN(4), .NCH(2)) bus1 ();

   g_nlogic_pipe #(.NIN(4), .NCH(2), .CNTW(8)) u0 (
      .CK(CK), .RN(RN), .bus(bus0), .ERR(err0), .CNT(cnt0), .dbg_state_o(st0)
   );

   g_nlogic_pipe #(.NIN(4), .NCH(2), .CNTW(2)) u1 (
      .CK(CK), .RN(RN), .bus(bus1), .ERR(err1), .CNT(cnt1), .dbg_state_o(st1)
   );

   task automatic tick();
      @(posedge CK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   initial begin
      bus0.D = '1; bus0.OP = 3'd0; bus0.VI = 1'b1; bus0.RDYO = 1'b1;
      bus1.D = '0; bus1.OP = 3'd0; bus1.VI = 1'b0; bus1.RDYO = 1'b1;

      // 1: reset held 3 cycles with VI=1
      RN = 1'b0;
      repeat (3) tick();
      chk("rst_vo",   32'(bus0.VO),   32'd0);
      chk("rst_rdyi", 32'(bus0.RDYI), 32'd1);
      chk("rst_y",    32'(bus0.Y),    32'd0);
      chk("rst_cnt",  32'(cnt0),      32'd0);
      chk("rst_err",  32'(err0),      32'd0);
      bus0.VI = 1'b0;
      RN = 1'b1;
      tick();
      chk("rel_vo",   32'(bus0.VO),   32'd0);

      // 2: all ops back-to-back with RDYO=1
      bus0.D = 8'b0110_1111;
      bus0.VI = 1'b1;
      for (int k = 0; k < 6; k++) begin
         bus0.OP = 3'(k);
         tick();
         chk("op_y",    32'(bus0.Y),    32'(exp_ops[k]));
         chk("op_vo",   32'(bus0.VO),   32'd1);
         chk("op_rdyi", 32'(bus0.RDYI), 32'd1);
      end
      bus0.D = 8'b0111_0001;
      bus0.OP = G_OP_XOR;
      tick();
      chk("xor_odd_y", 32'(bus0.Y), 32'b11);
      bus0.OP = G_OP_XNOR;
      tick();
      chk("xnor_odd_y", 32'(bus0.Y), 32'b00);
      bus0.VI = 1'b0;
      tick();
      chk("ops_vo_done", 32'(bus0.VO), 32'd0);
      chk("ops_cnt",     32'(cnt0),    32'd8);

      // 3: backpressure, third push must be refused
      bus0.D = 8'b0110_1111;
      bus0.RDYO = 1'b0;
      bus0.VI = 1'b1;
      bus0.OP = G_OP_AND;
      tick();
      chk("bp1_rdyi", 32'(bus0.RDYI), 32'd1);
      bus0.OP = G_OP_OR;
      tick();
      chk("bp2_rdyi", 32'(bus0.RDYI), 32'd0);
      chk("bp2_y",    32'(bus0.Y),    32'b01);
      bus0.OP = G_OP_NOR;
      tick();
      chk("bp3_y",    32'(bus0.Y),    32'b01);
      chk("bp3_vo",   32'(bus0.VO),   32'd1);
      bus0.VI = 1'b0;
      tick();
      chk("bp_hold_y", 32'(bus0.Y),   32'b01);
      bus0.RDYO = 1'b1;
      tick();
      chk("bp_d1_y",    32'(bus0.Y),    32'b11);
      chk("bp_d1_rdyi", 32'(bus0.RDYI), 32'd1);
      tick();
      chk("bp_d2_vo",  32'(bus0.VO), 32'd0);
      chk("bp_cnt",    32'(cnt0),    32'd10);

      // 4: full with simultaneous deliver and VI
      bus0.RDYO = 1'b0;
      bus0.VI = 1'b1;
      bus0.OP = G_OP_NAND;
      tick();
      bus0.OP = G_OP_OR;
      tick();
      chk("sim_full_rdyi", 32'(bus0.RDYI), 32'd0);
      chk("sim_full_y",    32'(bus0.Y),    32'b10);
      bus0.RDYO = 1'b1;
      bus0.OP = G_OP_AND;
      tick();
      chk("sim_s1_y",    32'(bus0.Y),    32'b11);
      chk("sim_s1_rdyi", 32'(bus0.RDYI), 32'd1);
      tick();
      chk("sim_s2_y",    32'(bus0.Y),    32'b01);
      bus0.VI = 1'b0;
      tick();
      chk("sim_vo_done", 32'(bus0.VO),   32'd0);
      chk("sim_cnt",     32'(cnt0),      32'd13);

      // 5: reserved op sets sticky ERR, result forced to zero
      bus0.VI = 1'b1;
      bus0.OP = 3'd6;
      tick();
      chk("rsv_y",   32'(bus0.Y),  32'b00);
      chk("rsv_vo",  32'(bus0.VO), 32'd1);
      chk("rsv_err", 32'(err0),    32'd1);
      bus0.OP = G_OP_AND;
      tick();
      chk("rsv_next_y",   32'(bus0.Y), 32'b01);
      chk("rsv_next_err", 32'(err0),   32'd1);
      bus0.VI = 1'b0;
      tick();
      chk("rsv_hold_err", 32'(err0), 32'd1);
      chk("rsv_cnt",      32'(cnt0), 32'd15);
      RN = 1'b0;
      tick();
      chk("rsv_clr_err", 32'(err0), 32'd0);
      chk("rsv_clr_cnt", 32'(cnt0), 32'd0);
      RN = 1'b1;

      // 6: 2-bit counter saturation, then reset while stalled
      bus1.D = 8'b0110_1111;
      bus1.OP = G_OP_OR;
      bus1.RDYO = 1'b1;
      bus1.VI = 1'b1;
      repeat (3) tick();
      chk("sat_mid_cnt", 32'(cnt1), 32'd2);
      repeat (2) tick();
      bus1.VI = 1'b0;
      tick();
      chk("sat_cnt", 32'(cnt1),    32'd3);
      chk("sat_vo",  32'(bus1.VO), 32'd0);
      bus1.RDYO = 1'b0;
      bus1.VI = 1'b1;
      bus1.OP = G_OP_AND;
      repeat (2) tick();
      chk("stall_vo",   32'(bus1.VO),   32'd1);
      chk("stall_rdyi", 32'(bus1.RDYI), 32'd0);
      RN = 1'b0;
      tick();
      chk("mid_rst_vo",   32'(bus1.VO),   32'd0);
      chk("mid_rst_rdyi", 32'(bus1.RDYI), 32'd1);
      chk("mid_rst_y",    32'(bus1.Y),    32'd0);
      chk("mid_rst_cnt",  32'(cnt1),      32'd0);
      RN = 1'b1;
      bus1.VI = 1'b0;
      bus1.RDYO = 1'b1;
      tick();
      chk("post_rst_vo",  32'(bus1.VO), 32'd0);
      tick();
      chk("post_rst_cnt", 32'(cnt1),    32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
